// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// the NOP word, the default memory size and the fetch address check.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BUBBLE  = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_STALLED = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP               = 32'h0000_0000;
  localparam int          DEFAULT_MEM_DEPTH = 128;

  // A fetch is bad when it is not word aligned or its word index falls
  // beyond the last implemented memory word.
  function automatic logic addr_bad(input logic [31:0] pc, input logic [31:0] depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, pc[31:2]};
    return (pc[1:0] != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/instruction_memory_sync.sv
// Single-clock instruction memory: one synchronous read port with enable,
// one synchronous write port. A same-index read and write in one cycle
// returns the old word. The array itself is never cleared by reset.
module instruction_memory_sync #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Next read data: load the addressed word when enabled, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read data register; reset only clears the output, not the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= 32'h0000_0000;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // Array write; writes arriving while reset is held are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: reads the word at PCResult from local memory and
// presents it with its PC and PC+4 through the IF/ID register. Handles
// stall, flush and a sticky fault on misaligned or out-of-range fetches.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      PCResult,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             ProgWrEn,
  input  logic [IDX_W-1:0] ProgAddr,
  input  logic [31:0]      ProgData,
  output logic [31:0]      Instruction,
  output logic [31:0]      FetchPC,
  output logic [31:0]      PCPlus4,
  output logic             Valid,
  output logic             Fault,
  output logic [31:0]      FetchCount
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         valid_q, valid_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;
  // Set when the memory read register holds the live instruction; cleared
  // for bubbles so Instruction reads as NOP.
  logic         live_q, live_d;
  logic         rd_en_s;
  logic         bad_s;
  logic [31:0]  rd_data_s;

  assign bad_s = addr_bad(PCResult, 32'(MEM_DEPTH));

  instruction_memory_sync #(
    .DEPTH (MEM_DEPTH),
    .AW    (IDX_W)
  ) u_imem (
    .clk     (Clk),
    .rst     (Reset),
    .rd_en   (rd_en_s),
    .rd_addr (PCResult[IDX_W+1:2]),
    .rd_data (rd_data_s),
    .wr_en   (ProgWrEn),
    .wr_addr (ProgAddr),
    .wr_data (ProgData)
  );

  // Next-state and IF/ID update: flush beats stall, stall beats capture,
  // and a bad address turns a would-be capture into a permanent fault.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    count_d    = count_q;
    live_d     = live_q;
    rd_en_s    = 1'b0;
    case (state_q)
      ST_BUBBLE, ST_ACTIVE, ST_STALLED: begin
        if (Flush) begin
          fetch_pc_d = PCResult;
          pc_plus4_d = PCResult + 32'd4;
          valid_d    = 1'b0;
          live_d     = 1'b0;
          state_d    = ST_ACTIVE;
        end else if (Stall) begin
          state_d    = ST_STALLED;
        end else if (bad_s) begin
          fault_d    = 1'b1;
          valid_d    = 1'b0;
          live_d     = 1'b0;
          state_d    = ST_FAULT;
        end else begin
          rd_en_s    = 1'b1;
          fetch_pc_d = PCResult;
          pc_plus4_d = PCResult + 32'd4;
          valid_d    = 1'b1;
          live_d     = 1'b1;
          count_d    = count_q + 32'd1;
          state_d    = ST_ACTIVE;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_BUBBLE;
      end
    endcase
  end

  // State and IF/ID register; reset drops any capture in progress.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_BUBBLE;
      fetch_pc_q <= 32'h0000_0000;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= 32'h0000_0000;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      live_q     <= live_d;
    end
  end

  assign Instruction = live_q ? rd_data_s : NOP;
  assign FetchPC     = fetch_pc_q;
  assign PCPlus4     = pc_plus4_q;
  assign Valid       = valid_q;
  assign Fault       = fault_q;
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: cycle-by-cycle vector tables with a
// scoreboard queue of expected IF/ID values, plus hand-written async resets.
module tb_instruction_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCResult;
  logic        Stall;
  logic        Flush;
  logic        ProgWrEn;
  logic [6:0]  ProgAddr;
  logic [31:0] ProgData;
  logic [31:0] Instruction;
  logic [31:0] FetchPC;
  logic [31:0] PCPlus4;
  logic        Valid;
  logic        Fault;
  logic [31:0] FetchCount;

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        wr;
    logic [6:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_instr;
    logic [31:0] e_fpc;
    logic [31:0] e_p4;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total;
  int   passed;

  instruction_fetch_stage dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PCResult    (PCResult),
    .Stall       (Stall),
    .Flush       (Flush),
    .ProgWrEn    (ProgWrEn),
    .ProgAddr    (ProgAddr),
    .ProgData    (ProgData),
    .Instruction (Instruction),
    .FetchPC     (FetchPC),
    .PCPlus4     (PCPlus4),
    .Valid       (Valid),
    .Fault       (Fault),
    .FetchCount  (FetchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] pc, input logic st, input logic fl,
                     input logic wr, input logic [6:0] wa, input logic [31:0] wd,
                     input logic [31:0] ei, input logic [31:0] efpc, input logic [31:0] ep4,
                     input logic ev, input logic ef, input logic [31:0] ec);
    vec_t v;
    v.pc = pc; v.stall = st; v.flush = fl; v.wr = wr; v.waddr = wa; v.wdata = wd;
    v.e_instr = ei; v.e_fpc = efpc; v.e_p4 = ep4; v.e_valid = ev; v.e_fault = ef; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  // Apply every queued row for one clock, then compare outputs 1 time unit
  // after the edge against the expectation pushed when the row was driven.
  task automatic run_rows(input string tag);
    vec_t v;
    vec_t e;
    for (int i = 0; tbl.size() > 0; i++) begin
      v = tbl.pop_front();
      PCResult = v.pc;
      Stall    = v.stall;
      Flush    = v.flush;
      ProgWrEn = v.wr;
      ProgAddr = v.waddr;
      ProgData = v.wdata;
      exp_q.push_back(v);
      @(posedge Clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d].Instruction", tag, i), Instruction, e.e_instr);
      chk($sformatf("%s[%0d].FetchPC", tag, i), FetchPC, e.e_fpc);
      chk($sformatf("%s[%0d].PCPlus4", tag, i), PCPlus4, e.e_p4);
      chk($sformatf("%s[%0d].Valid", tag, i), {31'd0, Valid}, {31'd0, e.e_valid});
      chk($sformatf("%s[%0d].Fault", tag, i), {31'd0, Fault}, {31'd0, e.e_fault});
      chk($sformatf("%s[%0d].FetchCount", tag, i), FetchCount, e.e_cnt);
    end
    ProgWrEn = 1'b0;
  endtask

  // Assert reset between clock edges, confirm outputs clear before the
  // next edge, then release with the given Stall/PCResult already driven.
  task automatic async_reset(input string tag, input logic st, input logic [31:0] pc);
    #3;
    Reset    = 1'b1;
    Stall    = st;
    Flush    = 1'b0;
    PCResult = pc;
    ProgWrEn = 1'b0;
    #1;
    chk({tag, ".Instruction"}, Instruction, 32'h0);
    chk({tag, ".FetchPC"}, FetchPC, 32'h0);
    chk({tag, ".PCPlus4"}, PCPlus4, 32'h0);
    chk({tag, ".Valid"}, {31'd0, Valid}, 32'h0);
    chk({tag, ".Fault"}, {31'd0, Fault}, 32'h0);
    chk({tag, ".FetchCount"}, FetchCount, 32'h0);
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    Reset    = 1'b1;
    PCResult = 32'h0;
    Stall    = 1'b1;
    Flush    = 1'b0;
    ProgWrEn = 1'b0;
    ProgAddr = 7'd0;
    ProgData = 32'h0;

    async_reset("rst0", 1'b1, 32'h0);

    // Load under stall (outputs stay at reset values), then fetch.
    add(32'd0,   1'b1, 1'b0, 1'b1, 7'd0,   32'h2008_0005, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    add(32'd0,   1'b1, 1'b0, 1'b1, 7'd1,   32'h2009_000A, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    add(32'd0,   1'b1, 1'b0, 1'b1, 7'd2,   32'h3333_3333, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    add(32'd0,   1'b1, 1'b0, 1'b1, 7'd3,   32'h1111_1111, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    add(32'd0,   1'b1, 1'b0, 1'b1, 7'd4,   32'h4444_4444, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    add(32'd0,   1'b1, 1'b0, 1'b1, 7'd127, 32'h7F7F_7F7F, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    add(32'd0,   1'b0, 1'b0, 1'b0, 7'd0,   32'h0, 32'h2008_0005, 32'd0,  32'd4,  1'b1, 1'b0, 32'd1);
    add(32'd4,   1'b0, 1'b0, 1'b0, 7'd0,   32'h0, 32'h2009_000A, 32'd4,  32'd8,  1'b1, 1'b0, 32'd2);
    add(32'd8,   1'b1, 1'b0, 1'b0, 7'd0,   32'h0, 32'h2009_000A, 32'd4,  32'd8,  1'b1, 1'b0, 32'd2);
    add(32'd12,  1'b1, 1'b0, 1'b0, 7'd0,   32'h0, 32'h2009_000A, 32'd4,  32'd8,  1'b1, 1'b0, 32'd2);
    add(32'd12,  1'b1, 1'b0, 1'b0, 7'd0,   32'h0, 32'h2009_000A, 32'd4,  32'd8,  1'b1, 1'b0, 32'd2);
    add(32'd12,  1'b0, 1'b0, 1'b0, 7'd0,   32'h0, 32'h1111_1111, 32'd12, 32'd16, 1'b1, 1'b0, 32'd3);
    add(32'd16,  1'b1, 1'b1, 1'b0, 7'd0,   32'h0, 32'h0,         32'd16, 32'd20, 1'b0, 1'b0, 32'd3);
    add(32'd12,  1'b0, 1'b0, 1'b1, 7'd3,   32'hDEAD_BEEF, 32'h1111_1111, 32'd12, 32'd16, 1'b1, 1'b0, 32'd4);
    add(32'd12,  1'b0, 1'b0, 1'b0, 7'd0,   32'h0, 32'hDEAD_BEEF, 32'd12, 32'd16, 1'b1, 1'b0, 32'd5);
    add(32'd8,   1'b0, 1'b0, 1'b0, 7'd0,   32'h0, 32'h3333_3333, 32'd8,  32'd12, 1'b1, 1'b0, 32'd6);
    add(32'd508, 1'b0, 1'b0, 1'b0, 7'd0,   32'h0, 32'h7F7F_7F7F, 32'd508, 32'd512, 1'b1, 1'b0, 32'd7);
    add(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 7'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'd7);
    add(32'd16,  1'b0, 1'b0, 1'b0, 7'd0,   32'h0, 32'h4444_4444, 32'd16, 32'd20, 1'b1, 1'b0, 32'd8);
    run_rows("main");

    // Mid-run reset: memory survives, then misaligned fetch faults for good.
    async_reset("rst1", 1'b1, 32'h0);
    add(32'd0,   1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0,         32'd0,  32'd0,  1'b0, 1'b0, 32'd0);
    add(32'd0,   1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h2008_0005, 32'd0,  32'd4,  1'b1, 1'b0, 32'd1);
    add(32'd12,  1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'hDEAD_BEEF, 32'd12, 32'd16, 1'b1, 1'b0, 32'd2);
    add(32'd6,   1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 32'd12, 32'd16, 1'b0, 1'b1, 32'd2);
    add(32'd512, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 32'd12, 32'd16, 1'b0, 1'b1, 32'd2);
    add(32'd0,   1'b0, 1'b1, 1'b0, 7'd0, 32'h0, 32'h0, 32'd12, 32'd16, 1'b0, 1'b1, 32'd2);
    add(32'd0,   1'b1, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 32'd12, 32'd16, 1'b0, 1'b1, 32'd2);
    add(32'd4,   1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 32'd12, 32'd16, 1'b0, 1'b1, 32'd2);
    run_rows("fault");

    // Out-of-range fetch straight from reset; a write during FAULT still lands.
    async_reset("rst2", 1'b0, 32'd512);
    add(32'd512, 1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    add(32'd0,   1'b0, 1'b0, 1'b1, 7'd0, 32'hCAFE_F00D, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    add(32'd0,   1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0);
    run_rows("range");

    async_reset("rst3", 1'b0, 32'd0);
    add(32'd0,   1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'hCAFE_F00D, 32'd0, 32'd4, 1'b1, 1'b0, 32'd1);
    add(32'd4,   1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 32'h2009_000A, 32'd4, 32'd8, 1'b1, 1'b0, 32'd2);
    run_rows("post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Downstream neighbour of the program counter register.
- Consumes PCResult each cycle, reads the instruction word from a local synchronous instruction memory, and presents it with its PC and PC+4 to the decode stage through an IF/ID output register.
- Supports stall (hold) and flush (squash) from the hazard logic.
- Flags misaligned and out-of-range fetches with a sticky fault.

Parameters:
- MEM_DEPTH, 128: number of 32-bit instruction words. Index = PCResult[31:2].
- IDX_W, 7: index width, equal to clog2(MEM_DEPTH).

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- PCResult  input  32  byte address from the program counter
- Stall  input  1  hold the IF/ID register contents
- Flush  input  1  squash the instruction being captured
- ProgWrEn  input  1  instruction memory write enable (loader/bench)
- ProgAddr  input  IDX_W  word index for the write
- ProgData  input  32  word to write
- Instruction  output  32  fetched instruction (IF/ID)
- FetchPC  output  32  PC of Instruction
- PCPlus4  output  32  FetchPC + 4
- Valid  output  1  Instruction is real (not a bubble)
- Fault  output  1  sticky misaligned/out-of-range flag
- FetchCount  output  32  count of valid captures

Behaviour:
- Reset (async, active-high):
  - Instruction, FetchPC, PCPlus4, Valid, Fault and FetchCount go to 0 immediately.
  - State goes to BUBBLE.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards any in-flight capture.
- States: BUBBLE, ACTIVE, STALLED, FAULT (2-bit encoding, from the package).
- BUBBLE:
  - Entered from reset.
  - Outputs hold their reset values.
  - On the first posedge with Reset low, performs a normal capture and moves to ACTIVE, or to FAULT if the address is bad.
- Capture (ACTIVE, Stall=0, Flush=0, address good):
  - Instruction <= mem[PCResult[IDX_W+1:2]].
  - FetchPC <= PCResult.
  - PCPlus4 <= PCResult + 4, modulo 2^32 (0xFFFFFFFC gives 0).
  - Valid <= 1.
  - FetchCount <= FetchCount + 1, wrapping at 2^32.
  - Latency: one clock edge from PCResult to Instruction.
- Stall=1, Flush=0:
  - All IF/ID outputs and FetchCount hold.
  - State goes to STALLED.
  - Leaving STALLED (Stall=0) performs a capture of the current PCResult in that cycle and returns to ACTIVE.
- Flush=1:
  - Has priority over Stall.
  - Instruction <= 0 (NOP), Valid <= 0.
  - FetchPC and PCPlus4 still update from PCResult.
  - FetchCount does not increment.
  - State goes to ACTIVE.
- Bad address (PCResult[1:0] != 0, or PCResult[31:2] >= MEM_DEPTH) on a would-be capture:
  - Fault <= 1, Valid <= 0, Instruction <= 0.
  - State goes to FAULT.
- FAULT:
  - Absorbing until Reset.
  - Outputs frozen.
  - Stall and Flush are ignored.
- Memory write port:
  - Accepted in every state and during Stall.
  - A write and a read to the same index in the same cycle returns the old data (read-before-write).
- ProgWrEn with Reset asserted: write is ignored.

Decomposition:
- Shared package `fetch_pkg` holds:
  - state encoding constants;
  - NOP = 32'h0000_0000;
  - default MEM_DEPTH.
- One sub-module, `instruction_memory_sync`:
  - one synchronous read port with read enable;
  - one synchronous write port;
  - read-before-write.
- The top module holds the FSM, the IF/ID register, the address checks and the counter.

Test Plan:
- Reset, then load mem[0]=0x20080005 and mem[1]=0x2009000A; drive PCResult=0 then 4. Required: Instruction 0x20080005 with FetchPC 0 and PCPlus4 4, then 0x2009000A with FetchPC 4 and PCPlus4 8; Valid=1; FetchCount=2.
- Stall for 3 cycles while PCResult changes 8→12. Required: outputs keep the PC=4 values and FetchCount stays 2. After release, the PC=12 word is captured.
- Assert Flush and Stall together with PCResult=16. Required: Valid=0, Instruction=0, FetchPC=16, FetchCount unchanged.
- PCResult=6 (misaligned), then PCResult=512 with MEM_DEPTH=128. Required: Fault=1 and Valid=0 on the first case; later fetches are ignored until Reset.
- Write mem[3]=0xDEADBEEF in the same cycle as a fetch of PC=12 (old value 0x11111111). Required: 0x11111111 is captured; the next fetch of 12 gives 0xDEADBEEF.
- Assert Reset asynchronously between clock edges during ACTIVE. Required: all outputs are 0 before the next edge, and memory contents are retained after release.
